brownout_seq: RTL and testbench

//  Digital sequencer for the brownout analog core, clocked from the RC oscillator (osc_ck).

---
 rtl/brownout_seq.sv | 186 ++++++++++++++++++
 tb/tb_brownout_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/brownout_seq.sv
// Brownout analog-core sequencer: comparator power-up/settling, trip-code application,
// comparator deglitching and the one-shot hold timer that stretches the brownout reset.
module brownout_seq #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FILT_LEN      = 4,
  parameter int TMR_W         = 12,
  parameter int LONG_HOLD     = 2048,
  parameter int SHORT_HOLD    = 4
) (
  input  logic       osc_ck,
  input  logic       rst,
  input  logic       ena,
  input  logic       force_short_oneshot,
  input  logic [2:0] otrip_req,
  input  logic [2:0] vtrip_req,
  input  logic       cmp_brout,
  input  logic       cmp_vunder,
  output logic       comp_ena,
  output logic [2:0] otrip,
  output logic [2:0] vtrip,
  output logic       brout_filt,
  output logic       vunder,
  output logic       out,
  output logic       timed_out,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_MONITOR = 3'd3,
    ST_BLANK   = 3'd4
  } state_t;

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FC_ZERO     = FC_W'(0);
  localparam logic [FC_W-1:0]  FC_ONE      = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(FILT_LEN - 1);
  localparam logic [TMR_W-1:0] CNT_ZERO    = TMR_W'(0);
  localparam logic [TMR_W-1:0] CNT_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LONG_LOAD   = TMR_W'(LONG_HOLD - 1);
  localparam logic [TMR_W-1:0] SHORT_LOAD  = TMR_W'(SHORT_HOLD - 1);

  state_t           state_r, state_n_s;
  logic [TMR_W-1:0] cnt_r, cnt_n_s, hold_load_s;
  logic [2:0]       otrip_r, otrip_n_s, vtrip_r, vtrip_n_s;
  logic             out_r, out_n_s, comp_ena_r, comp_ena_n_s, timed_out_r, timed_out_n_s;
  // Channel 0 is brownout, channel 1 is undervoltage.
  logic [1:0]       sync1_r, sync2_r, filt_r, filt_n_s;
  logic [FC_W-1:0]  fcnt_r [2];
  logic [FC_W-1:0]  fcnt_n_s [2];

  assign hold_load_s = force_short_oneshot ? SHORT_LOAD : LONG_LOAD;

  // Deglitch filters: cleared while the comparators are unpowered/settling, frozen while blanked.
  always_comb begin
    filt_n_s = filt_r;
    for (int i = 0; i < 2; i++) begin
      fcnt_n_s[i] = fcnt_r[i];
      if (state_r == ST_OFF || state_r == ST_SETTLE) begin
        fcnt_n_s[i] = FC_ZERO;
        filt_n_s[i] = 1'b0;
      end else if (state_r == ST_BLANK) begin
        fcnt_n_s[i] = fcnt_r[i];
      end else if (sync2_r[i] == filt_r[i]) begin
        fcnt_n_s[i] = FC_ZERO;
      end else if (fcnt_r[i] == FC_LAST) begin
        fcnt_n_s[i] = FC_ZERO;
        filt_n_s[i] = ~filt_r[i];
      end else begin
        fcnt_n_s[i] = fcnt_r[i] + FC_ONE;
      end
    end
  end

  // Sequencer next state, timer and trip-code handling; outputs follow the next state.
  always_comb begin
    state_n_s     = state_r;
    cnt_n_s       = cnt_r;
    otrip_n_s     = otrip_r;
    vtrip_n_s     = vtrip_r;
    timed_out_n_s = 1'b0;
    if (!ena) begin
      state_n_s = ST_OFF;
      cnt_n_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_OFF: begin
          otrip_n_s = otrip_req;
          vtrip_n_s = vtrip_req;
          cnt_n_s   = SETTLE_LOAD;
          state_n_s = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_n_s   = hold_load_s;
            state_n_s = ST_HOLD;
          end else begin
            cnt_n_s = cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (filt_r[0]) begin
            cnt_n_s = hold_load_s;
          end else if (cnt_r == CNT_ZERO) begin
            timed_out_n_s = 1'b1;
            state_n_s     = ST_MONITOR;
          end else begin
            cnt_n_s = cnt_r - CNT_ONE;
          end
        end
        ST_MONITOR: begin
          if (filt_r[0]) begin
            cnt_n_s   = hold_load_s;
            state_n_s = ST_HOLD;
          end else if ({otrip_req, vtrip_req} != {otrip_r, vtrip_r}) begin
            otrip_n_s = otrip_req;
            vtrip_n_s = vtrip_req;
            cnt_n_s   = SETTLE_LOAD;
            state_n_s = ST_BLANK;
          end else begin
            cnt_n_s = cnt_r;
          end
        end
        ST_BLANK: begin
          if (cnt_r == CNT_ZERO) begin
            state_n_s = ST_MONITOR;
          end else begin
            cnt_n_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          cnt_n_s   = CNT_ZERO;
          state_n_s = ST_OFF;
        end
      endcase
    end
    out_n_s      = (state_n_s == ST_OFF) || (state_n_s == ST_SETTLE) || (state_n_s == ST_HOLD);
    comp_ena_n_s = (state_n_s != ST_OFF);
  end

  // State, synchronizer, filter and output registers.
  always_ff @(posedge osc_ck) begin
    if (rst) begin
      state_r     <= ST_OFF;
      cnt_r       <= CNT_ZERO;
      otrip_r     <= 3'd0;
      vtrip_r     <= 3'd0;
      out_r       <= 1'b1;
      comp_ena_r  <= 1'b0;
      timed_out_r <= 1'b0;
      sync1_r     <= 2'b00;
      sync2_r     <= 2'b00;
      filt_r      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        fcnt_r[i] <= FC_ZERO;
      end
    end else begin
      state_r     <= state_n_s;
      cnt_r       <= cnt_n_s;
      otrip_r     <= otrip_n_s;
      vtrip_r     <= vtrip_n_s;
      out_r       <= out_n_s;
      comp_ena_r  <= comp_ena_n_s;
      timed_out_r <= timed_out_n_s;
      sync1_r     <= {cmp_vunder, cmp_brout};
      sync2_r     <= sync1_r;
      filt_r      <= filt_n_s;
      for (int i = 0; i < 2; i++) begin
        fcnt_r[i] <= fcnt_n_s[i];
      end
    end
  end

  assign comp_ena   = comp_ena_r;
  assign otrip      = otrip_r;
  assign vtrip      = vtrip_r;
  assign brout_filt = filt_r[0];
  assign vunder     = filt_r[1];
  assign out        = out_r;
  assign timed_out  = timed_out_r;
  assign state      = state_r;

endmodule

// File: tb/tb_brownout_seq.sv
// Directed self-checking bench for brownout_seq: reset, power-up timing, deglitching,
// hold retrigger (long and short), trip-code blanking, disable and reset priority.
module tb_brownout_seq;

  logic       osc_ck = 1'b0;
  logic       rst, ena, force_short_oneshot, cmp_brout, cmp_vunder;
  logic [2:0] otrip_req, vtrip_req;
  logic       comp_ena, brout_filt, vunder, out, timed_out;
  logic [2:0] otrip, vtrip, state;

  int total = 0;
  int bad   = 0;

  brownout_seq dut (
    .osc_ck(osc_ck), .rst(rst), .ena(ena), .force_short_oneshot(force_short_oneshot),
    .otrip_req(otrip_req), .vtrip_req(vtrip_req), .cmp_brout(cmp_brout), .cmp_vunder(cmp_vunder),
    .comp_ena(comp_ena), .otrip(otrip), .vtrip(vtrip), .brout_filt(brout_filt), .vunder(vunder),
    .out(out), .timed_out(timed_out), .state(state)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge osc_ck);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; force_short_oneshot = 1'b0;
    otrip_req = 3'd0; vtrip_req = 3'd0; cmp_brout = 1'b0; cmp_vunder = 1'b0;

    // 1: reset values
    tick(2);
    chk("rst_out", 32'(out), 32'd1);
    chk("rst_comp_ena", 32'(comp_ena), 32'd0);
    chk("rst_otrip", 32'(otrip), 32'd0);
    chk("rst_vtrip", 32'(vtrip), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    chk("rst_brout_filt", 32'(brout_filt), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("off_idle_state", 32'(state), 32'd0);

    // 2: power-up, settle and first hold
    otrip_req = 3'd7; vtrip_req = 3'd5; ena = 1'b1;
    tick(1);
    chk("pu_state", 32'(state), 32'd1);
    chk("pu_comp_ena", 32'(comp_ena), 32'd1);
    chk("pu_otrip", 32'(otrip), 32'd7);
    chk("pu_vtrip", 32'(vtrip), 32'd5);
    chk("pu_out", 32'(out), 32'd1);
    tick(15);
    chk("settle_last", 32'(state), 32'd1);
    tick(1);
    chk("hold_entry", 32'(state), 32'd2);
    tick(2047);
    chk("hold_last_out", 32'(out), 32'd1);
    chk("hold_last_to", 32'(timed_out), 32'd0);
    tick(1);
    chk("release_out", 32'(out), 32'd0);
    chk("release_to", 32'(timed_out), 32'd1);
    chk("release_state", 32'(state), 32'd3);
    tick(1);
    chk("to_pulse_end", 32'(timed_out), 32'd0);

    // vunder filtering in MONITOR, no effect on out
    cmp_vunder = 1'b1;
    tick(5);
    chk("vunder_pre", 32'(vunder), 32'd0);
    tick(1);
    chk("vunder_rise", 32'(vunder), 32'd1);
    chk("vunder_out", 32'(out), 32'd0);
    cmp_vunder = 1'b0;
    tick(6);
    chk("vunder_fall", 32'(vunder), 32'd0);

    // 3a: short glitch is filtered
    cmp_brout = 1'b1;
    tick(3);
    cmp_brout = 1'b0;
    tick(10);
    chk("glitch_filt", 32'(brout_filt), 32'd0);
    chk("glitch_out", 32'(out), 32'd0);

    // 3b: real brownout with long hold
    cmp_brout = 1'b1;
    tick(5);
    chk("bo_filt_pre", 32'(brout_filt), 32'd0);
    tick(1);
    chk("bo_filt_rise", 32'(brout_filt), 32'd1);
    chk("bo_out_lag", 32'(out), 32'd0);
    tick(1);
    chk("bo_out_set", 32'(out), 32'd1);
    chk("bo_state", 32'(state), 32'd2);
    tick(3);
    cmp_brout = 1'b0;
    tick(5);
    chk("bo_filt_held", 32'(brout_filt), 32'd1);
    tick(1);
    chk("bo_filt_fall", 32'(brout_filt), 32'd0);
    tick(2047);
    chk("bo_hold_last", 32'(out), 32'd1);
    tick(1);
    chk("bo_release", 32'(out), 32'd0);
    chk("bo_timed_out", 32'(timed_out), 32'd1);

    // 4: short hold
    force_short_oneshot = 1'b1;
    cmp_brout = 1'b1;
    tick(6);
    chk("sh_filt_rise", 32'(brout_filt), 32'd1);
    tick(1);
    chk("sh_out_set", 32'(out), 32'd1);
    tick(3);
    cmp_brout = 1'b0;
    tick(6);
    chk("sh_filt_fall", 32'(brout_filt), 32'd0);
    tick(3);
    chk("sh_hold_last", 32'(out), 32'd1);
    tick(1);
    chk("sh_release", 32'(out), 32'd0);
    chk("sh_timed_out", 32'(timed_out), 32'd1);
    force_short_oneshot = 1'b0;
    tick(2);

    // 5: trip-code change and blanking
    otrip_req = 3'd3;
    tick(1);
    chk("tc_otrip", 32'(otrip), 32'd3);
    chk("tc_state", 32'(state), 32'd4);
    cmp_brout = 1'b1;
    tick(15);
    chk("blank_last", 32'(state), 32'd4);
    chk("blank_out", 32'(out), 32'd0);
    chk("blank_frozen", 32'(brout_filt), 32'd0);
    tick(1);
    chk("blank_exit", 32'(state), 32'd3);
    tick(3);
    chk("post_blank_pre", 32'(brout_filt), 32'd0);
    tick(1);
    chk("post_blank_rise", 32'(brout_filt), 32'd1);
    chk("post_blank_out0", 32'(out), 32'd0);
    tick(1);
    chk("post_blank_out1", 32'(out), 32'd1);
    chk("post_blank_hold", 32'(state), 32'd2);

    // 6: disable mid-HOLD, then reset mid-SETTLE
    ena = 1'b0;
    cmp_brout = 1'b0;
    tick(1);
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_out", 32'(out), 32'd1);
    chk("dis_comp_ena", 32'(comp_ena), 32'd0);
    chk("dis_otrip_kept", 32'(otrip), 32'd3);
    tick(1);
    chk("dis_filt_clr", 32'(brout_filt), 32'd0);
    otrip_req = 3'd6;
    ena = 1'b1;
    tick(1);
    chk("reen_state", 32'(state), 32'd1);
    chk("reen_otrip", 32'(otrip), 32'd6);
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_otrip", 32'(otrip), 32'd0);
    chk("rst_mid_comp_ena", 32'(comp_ena), 32'd0);
    chk("rst_mid_out", 32'(out), 32'd1);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
